// File: rtl/storage_write_arbiter_pkg.sv
// Shared definitions for storage_write_arbiter: FSM state encoding and index-width helper.
package storage_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Width of an index into n requesters; never less than one bit.
  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/storage_write_arbiter_rr_pick.sv
// Round-robin winner selection: first set bit of req scanning ptr, ptr+1, ... mod N.
module storage_write_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] win
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    valid = |req;
    win   = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/storage_write_arbiter.sv
// Round-robin writer for one shared W-bit register among N 4-phase req/ack requesters.
// Define STORAGE_WRITE_ARB_STATS_EN to add per-requester saturating write counters (wr_count).
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests from ptr
// GRANT | grant[win] high one cycle; requester may abandon by dropping req
// LOAD  | Q captures the winner's wdata at the exiting edge
// ACK   | ack[win] high until the winner releases req
module storage_write_arbiter
  import storage_write_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int PW = clog2_w(N)
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic [N-1:0]  req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]  grant,
  output logic [N-1:0]  ack,
  output logic [W-1:0]  Q,
  output logic [PW-1:0] owner,
  output logic          busy
`ifdef STORAGE_WRITE_ARB_STATS_EN
  ,
  output logic [N*8-1:0] wr_count
`endif
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t        state, state_nxt;
  logic [PW-1:0] win, win_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic          pick_valid;
  logic [PW-1:0] pick_win;
  logic          load;
  logic [W-1:0]  wd_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_wd
    assign wd_arr[g] = wdata[g*W +: W];
  end

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  storage_write_arbiter_rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    ptr_nxt   = ptr;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          win_nxt   = pick_win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (req[win]) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = inc_wrap(win);
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        if (!req[win]) begin
          state_nxt = IDLE;
          ptr_nxt   = inc_wrap(win);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant/ack are flops driven from the next state so they align exactly with GRANT/ACK.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      win   <= '0;
      ptr   <= '0;
      grant <= '0;
      ack   <= '0;
      Q     <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      ptr   <= ptr_nxt;
      grant <= (state_nxt == GRANT) ? (ONE << win_nxt) : '0;
      ack   <= (state_nxt == ACK)   ? (ONE << win_nxt) : '0;
      if (load) begin
        Q     <= wd_arr[win];
        owner <= win;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef STORAGE_WRITE_ARB_STATS_EN
  logic [7:0] cnt [N];

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (load && cnt[win] != 8'hFF) begin
      cnt[win] <= cnt[win] + 8'd1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign wr_count[g*8 +: 8] = cnt[g];
  end
`endif

endmodule
